// File: rtl/sensor_debounce_if.sv
// Signal bundle between a raw sensor line / host readout and the debouncer.
// The master side drives the raw line and clear; the slave is the debouncer itself.
interface sensor_debounce_if #(
  parameter int unsigned COUNT_WIDTH = 16
);
  logic                   in;
  logic                   clear;
  logic                   out;
  logic                   rise_pulse;
  logic                   fall_pulse;
  logic [COUNT_WIDTH-1:0] rise_count;
  logic [7:0]             glitch_count;

  modport master (
    output in, clear,
    input  out, rise_pulse, fall_pulse, rise_count, glitch_count
  );

  modport slave (
    input  in, clear,
    output out, rise_pulse, fall_pulse, rise_count, glitch_count
  );
endinterface

// File: rtl/sensor_debounce.sv
// Synchronises one raw sensor line, accepts a level only after STABLE_CYCLES
// identical samples, and keeps saturating accepted-rise and glitch counters.
module sensor_debounce #(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter bit          INVERT        = 1'b0,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic              clk,
  input  logic              reset,
  sensor_debounce_if.slave  bus
);

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_CHK,
    S_HIGH,
    S_FALL_CHK
  } state_t;

  localparam logic [22:0] QMAX = 23'(STABLE_CYCLES - 1);

  state_t                 state_q;
  logic [22:0]            q_q;
  logic                   s1_q, s2_q;
  logic                   out_q, rise_q, fall_q;
  logic [COUNT_WIDTH-1:0] rise_cnt_q, rise_cnt_d;
  logic [7:0]             glitch_cnt_q, glitch_cnt_d;
  logic                   raw;
  logic                   glitch_evt;

  assign raw = bus.in ^ INVERT;

  // An aborted qualification is exactly a check state seeing the old level again.
  assign glitch_evt = ((state_q == S_RISE_CHK) && !s2_q) ||
                      ((state_q == S_FALL_CHK) &&  s2_q);

  // Rises are counted off the registered strobe, so clear during the strobe
  // cycle still keeps that event (loads 1).
  always_comb begin
    rise_cnt_d = rise_cnt_q;
    if (rise_q && (rise_cnt_q != '1)) rise_cnt_d = rise_cnt_q + 1'b1;
    if (bus.clear) rise_cnt_d = rise_q ? COUNT_WIDTH'(1) : '0;
  end

  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_evt && (glitch_cnt_q != '1)) glitch_cnt_d = glitch_cnt_q + 1'b1;
    if (bus.clear) glitch_cnt_d = glitch_evt ? 8'd1 : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOW;
      q_q          <= '0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      out_q        <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      rise_cnt_q   <= '0;
      glitch_cnt_q <= '0;
    end else begin
      s1_q         <= raw;
      s2_q         <= s1_q;
      rise_cnt_q   <= rise_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      case (state_q)
        S_LOW: begin
          out_q <= 1'b0;
          if (s2_q) begin
            q_q     <= 23'd1;
            state_q <= S_RISE_CHK;
          end
        end
        S_RISE_CHK: begin
          if (!s2_q) begin
            state_q <= S_LOW;
          end else if (q_q == QMAX) begin
            state_q <= S_HIGH;
            out_q   <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            q_q <= q_q + 23'd1;
          end
        end
        S_HIGH: begin
          out_q <= 1'b1;
          if (!s2_q) begin
            q_q     <= 23'd1;
            state_q <= S_FALL_CHK;
          end
        end
        S_FALL_CHK: begin
          if (s2_q) begin
            state_q <= S_HIGH;
          end else if (q_q == QMAX) begin
            state_q <= S_LOW;
            out_q   <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            q_q <= q_q + 23'd1;
          end
        end
        default: state_q <= S_LOW;
      endcase
    end
  end

  assign bus.out          = out_q;
  assign bus.rise_pulse   = rise_q;
  assign bus.fall_pulse   = fall_q;
  assign bus.rise_count   = rise_cnt_q;
  assign bus.glitch_count = glitch_cnt_q;

endmodule

// File: doc/sensor_debounce.md
Name: sensor_debounce

Overview:
- Conditions one raw maze sensor line (IR beam-break or lick contact) before it reaches the pulse-width stretcher and the downstream event logic.
- Synchronises the asynchronous input into clk and rejects glitches shorter than a programmable stable time.
- Outputs a clean level, one-cycle rise/fall strobes, and saturating event and glitch counters for host readout.
- Sits directly upstream of the minimum-width stage; `out` drives that stage's `in`.

Parameters:
- STABLE_CYCLES, 1_000, consecutive identical synchronised samples needed to accept a level change (1 ms at 1 MHz). Legal range 2 to 2^23-1.
- INVERT, 0, when 1 the raw input is inverted before synchronisation (active-low sensors).
- COUNT_WIDTH, 16, width of rise_count.

Ports:
- clk  input  1  system clock (1 MHz nominal)
- reset  input  1  synchronous, active-high reset
- in  input  1  raw asynchronous sensor line
- clear  input  1  synchronous clear of rise_count and glitch_count
- out  output  1  debounced level, registered
- rise_pulse  output  1  one-cycle strobe when out goes 0->1
- fall_pulse  output  1  one-cycle strobe when out goes 1->0
- rise_count  output  COUNT_WIDTH  accepted rising events, saturating
- glitch_count  output  8  rejected transitions, saturating

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - state=S_LOW.
  - out, rise_pulse and fall_pulse = 0.
  - rise_count and glitch_count = 0.
  - Qualify counter q (23 bits) = 0.
  - Sync flops s1 and s2 = 0.
- Synchroniser:
  - raw = in XOR INVERT.
  - s1 <= raw; s2 <= s1.
  - Only s2 is used downstream.
- State machine, evaluated on s2 every cycle:
  - S_LOW: out=0. If s2=1, q<=1 and go to S_RISE_CHK.
  - S_RISE_CHK: out=0.
    - If s2=0: go to S_LOW and increment glitch_count.
    - Else if q==STABLE_CYCLES-1: go to S_HIGH, out<=1, rise_pulse<=1.
    - Else: q<=q+1.
  - S_HIGH: out=1. If s2=0, q<=1 and go to S_FALL_CHK.
  - S_FALL_CHK: out=1.
    - If s2=1: go to S_HIGH and increment glitch_count.
    - Else if q==STABLE_CYCLES-1: go to S_LOW, out<=0, fall_pulse<=1.
    - Else: q<=q+1.
- Strobe timing:
  - rise_pulse and fall_pulse are high for exactly the one cycle in which out first shows its new value.
  - Otherwise they are 0.
- Latency:
  - Raw input changes, then holds stable.
  - out changes after clock edge STABLE_CYCLES+2, counting the first edge that samples the new raw value as edge 1.
  - Example: STABLE_CYCLES=4 gives out changing after edge 6.
- Rejection threshold:
  - A pulse on s2 shorter than STABLE_CYCLES cycles never changes out.
  - A pulse of exactly STABLE_CYCLES cycles is accepted.
- Counters:
  - rise_count increments on each rise_pulse cycle and saturates at all-ones (no wrap).
  - glitch_count increments on each aborted qualification and saturates at 255.
  - clear and increment in the same cycle: the counter loads 1 (event not lost).
  - clear with no increment: the counter loads 0.
  - clear does not affect state, out or q.
- Reset mid-operation:
  - Aborts any qualification. No strobe and no count for the aborted event.
  - If raw is high during and after reset, the block qualifies from S_LOW normally. This yields one rise_pulse and rise_count=1 after STABLE_CYCLES+2 edges following reset release.
- Timing: all outputs registered; no combinational path from in to any output.

Test Plan:
All scenarios use STABLE_CYCLES=4, INVERT=0.
- Reset behaviour: assert reset 3 cycles with in=1 -> all outputs 0 during reset. After release: out=1 and rise_pulse=1 for one cycle at edge 6, rise_count=1, glitch_count=0.
- Clean press and release: in 0->1, held 20 cycles, then 1->0, held 20 cycles.
  - out rises at edge 6 after the rise, with one rise_pulse.
  - out falls at edge 6 after the fall, with one fall_pulse.
  - rise_count=1.
- Glitch rejection: in high 3 cycles then low -> out stays 0, no strobes, glitch_count=1. Repeat with a 4-cycle pulse -> out=1 for 4 cycles, rise_count=1, one rise_pulse and one fall_pulse.
- Saturation with clear: COUNT_WIDTH=2, 5 accepted presses -> rise_count stops at 3. Pulse clear in the same cycle as the 6th rise_pulse -> rise_count=1. Pulse clear alone -> rise_count=0.
- Dropout while high: in held high, then low 2 cycles, then high again -> out stays 1, no fall_pulse, glitch_count=1.
- INVERT=1: in held 1 -> out=0. in 1->0 and held -> out=1 at edge 6 with one rise_pulse.
